axi_buffer: RTL and testbench

Parametrised AXI buffer placed between an `axi_channel` master and slave. Each of the five channels (AW, W, B, AR, R) gets an independent FIFO of configurable depth, with no combinational path between the two sides. The block is used for timing closure and for decoupling burst traffic across interconnect boundaries. It generalises a single pipeline register into per-channel depth, an explicit pass-through mode and optional occupancy statistics.

---
 rtl/axi_buffer_if.sv | 87 ++++++++
 rtl/axi_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_buffer_if.sv
// AXI channel bundle (AW, W, B, AR, R) shared by both sides of axi_buffer.
// The master modport drives requests and sinks responses; slave is the mirror.
interface axi_channel #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USER_W = 1
);
    logic                aw_valid;
    logic                aw_ready;
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;

    logic                w_valid;
    logic                w_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;

    logic                b_valid;
    logic                b_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;

    logic                ar_valid;
    logic                ar_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;

    logic                r_valid;
    logic                r_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );
endinterface

// File: rtl/axi_buffer.sv
// Per-channel AXI FIFO buffer; depth 0 on a channel makes it a plain wire.
// Define AXI_BUFFER_STATS_EN to add <ch>_level / <ch>_peak occupancy outputs.
module axi_buffer_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int LW   = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef AXI_BUFFER_STATS_EN
    ,
    output logic [LW-1:0]    level,
    output logic [LW-1:0]    peak
`endif
);
    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = in_data;
`ifdef AXI_BUFFER_STATS_EN
        assign level = '0;
        assign peak  = '0;
`endif
    end else begin : g_fifo
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wptr_q, wptr_d;
        logic [PW-1:0]    rptr_q, rptr_d;
        logic [LW-1:0]    count_q, count_d;
        logic             push, pop;

        // Handshakes look only at registered count, so there is no ready path through.
        always_comb begin
            in_ready  = (count_q != LW'(DEPTH)) && !rst;
            out_valid = (count_q != '0) && !rst;
            push      = in_valid && in_ready;
            pop       = out_valid && out_ready;
            wptr_d    = wptr_q;
            rptr_d    = rptr_q;
            count_d   = count_q;
            if (push) begin
                wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end

        assign out_data = mem_q[rptr_q];

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                count_q <= count_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wptr_q] <= in_data;
            end
        end

`ifdef AXI_BUFFER_STATS_EN
        logic [LW-1:0] peak_q, peak_d;

        always_comb begin
            peak_d = (count_d > peak_q) ? count_d : peak_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                peak_q <= '0;
            end else begin
                peak_q <= peak_d;
            end
        end

        assign level = count_q;
        assign peak  = peak_q;
`endif
    end
endmodule

module axi_buffer #(
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH  = 2,
    parameter int B_DEPTH  = 2,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH  = 2,
    localparam int AW_LW = (AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1),
    localparam int W_LW  = (W_DEPTH == 0)  ? 1 : $clog2(W_DEPTH + 1),
    localparam int B_LW  = (B_DEPTH == 0)  ? 1 : $clog2(B_DEPTH + 1),
    localparam int AR_LW = (AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1),
    localparam int R_LW  = (R_DEPTH == 0)  ? 1 : $clog2(R_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    axi_channel.slave   slv,
    axi_channel.master  mst
`ifdef AXI_BUFFER_STATS_EN
    ,
    output logic [AW_LW-1:0] aw_level,
    output logic [AW_LW-1:0] aw_peak,
    output logic [W_LW-1:0]  w_level,
    output logic [W_LW-1:0]  w_peak,
    output logic [B_LW-1:0]  b_level,
    output logic [B_LW-1:0]  b_peak,
    output logic [AR_LW-1:0] ar_level,
    output logic [AR_LW-1:0] ar_peak,
    output logic [R_LW-1:0]  r_level,
    output logic [R_LW-1:0]  r_peak
`endif
);
    localparam int ID_W   = $bits(slv.aw_id);
    localparam int ADDR_W = $bits(slv.aw_addr);
    localparam int DATA_W = $bits(slv.w_data);
    localparam int USER_W = $bits(slv.aw_user);

    // Fixed AXI fields: len 8 + size 3 + burst 2 + lock 1 + cache 4 + prot 3 + qos 4 + region 4.
    localparam int AX_W = ID_W + ADDR_W + 29 + USER_W;
    localparam int W_W  = DATA_W + DATA_W / 8 + 1 + USER_W;
    localparam int B_W  = ID_W + 2 + USER_W;
    localparam int R_W  = ID_W + DATA_W + 3 + USER_W;

    if (ID_W != $bits(mst.aw_id) || ADDR_W != $bits(mst.aw_addr) ||
        DATA_W != $bits(mst.w_data) || USER_W != $bits(mst.aw_user) ||
        $bits(slv.w_user) != $bits(mst.w_user) || $bits(slv.b_user) != $bits(mst.b_user) ||
        $bits(slv.ar_user) != $bits(mst.ar_user) || $bits(slv.r_user) != $bits(mst.r_user))
    begin : g_width_check
        $fatal(1, "axi_buffer: slv and mst ID/ADDR/DATA/USER widths differ");
    end

    if (AW_DEPTH > 256 || W_DEPTH > 256 || B_DEPTH > 256 ||
        AR_DEPTH > 256 || R_DEPTH > 256) begin : g_depth_check
        $fatal(1, "axi_buffer: channel depth above 256");
    end

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;

    assign aw_in = {slv.aw_id, slv.aw_addr, slv.aw_len, slv.aw_size, slv.aw_burst, slv.aw_lock,
                    slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size, mst.aw_burst, mst.aw_lock,
            mst.aw_cache, mst.aw_prot, mst.aw_qos, mst.aw_region, mst.aw_user} = aw_out;

    assign w_in = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_out;

    assign b_in = {mst.b_id, mst.b_resp, mst.b_user};
    assign {slv.b_id, slv.b_resp, slv.b_user} = b_out;

    assign ar_in = {slv.ar_id, slv.ar_addr, slv.ar_len, slv.ar_size, slv.ar_burst, slv.ar_lock,
                    slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_region, slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size, mst.ar_burst, mst.ar_lock,
            mst.ar_cache, mst.ar_prot, mst.ar_qos, mst.ar_region, mst.ar_user} = ar_out;

    assign r_in = {mst.r_id, mst.r_data, mst.r_resp, mst.r_last, mst.r_user};
    assign {slv.r_id, slv.r_data, slv.r_resp, slv.r_last, slv.r_user} = r_out;

    axi_buffer_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AX_W)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(slv.aw_valid), .in_ready(slv.aw_ready), .in_data(aw_in),
        .out_valid(mst.aw_valid), .out_ready(mst.aw_ready), .out_data(aw_out)
`ifdef AXI_BUFFER_STATS_EN
        , .level(aw_level), .peak(aw_peak)
`endif
    );

    axi_buffer_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(slv.w_valid), .in_ready(slv.w_ready), .in_data(w_in),
        .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(w_out)
`ifdef AXI_BUFFER_STATS_EN
        , .level(w_level), .peak(w_peak)
`endif
    );

    axi_buffer_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_data(b_in),
        .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(b_out)
`ifdef AXI_BUFFER_STATS_EN
        , .level(b_level), .peak(b_peak)
`endif
    );

    axi_buffer_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AX_W)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(slv.ar_valid), .in_ready(slv.ar_ready), .in_data(ar_in),
        .out_valid(mst.ar_valid), .out_ready(mst.ar_ready), .out_data(ar_out)
`ifdef AXI_BUFFER_STATS_EN
        , .level(ar_level), .peak(ar_peak)
`endif
    );

    axi_buffer_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(mst.r_valid), .in_ready(mst.r_ready), .in_data(r_in),
        .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(r_out)
`ifdef AXI_BUFFER_STATS_EN
        , .level(r_level), .peak(r_peak)
`endif
    );
endmodule

// File: tb/tb_axi_buffer.sv
// Bench for axi_buffer: dut0 mixes depths (AW 2, W 4, B pass-through, AR 4, R 2),
// dut1 has every channel at depth 1 for the half-rate throughput case.
module tb_axi_buffer;
    localparam int AW_PW = 66;
    localparam int W_PW  = 38;
    localparam int B_PW  = 7;
    localparam int R_PW  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_channel s0 ();
    axi_channel m0 ();
    axi_channel s1 ();
    axi_channel m1 ();

`ifdef AXI_BUFFER_STATS_EN
    logic [1:0] aw_level0, aw_peak0, r_level0, r_peak0;
    logic [2:0] w_level0, w_peak0, ar_level0, ar_peak0;
    logic       b_level0, b_peak0;
    logic       aw_level1, aw_peak1, w_level1, w_peak1, b_level1, b_peak1;
    logic       ar_level1, ar_peak1, r_level1, r_peak1;
`endif

    axi_buffer #(.AW_DEPTH(2), .W_DEPTH(4), .B_DEPTH(0), .AR_DEPTH(4), .R_DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .slv(s0), .mst(m0)
`ifdef AXI_BUFFER_STATS_EN
        , .aw_level(aw_level0), .aw_peak(aw_peak0), .w_level(w_level0), .w_peak(w_peak0)
        , .b_level(b_level0), .b_peak(b_peak0), .ar_level(ar_level0), .ar_peak(ar_peak0)
        , .r_level(r_level0), .r_peak(r_peak0)
`endif
    );

    axi_buffer #(.AW_DEPTH(1), .W_DEPTH(1), .B_DEPTH(1), .AR_DEPTH(1), .R_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .slv(s1), .mst(m1)
`ifdef AXI_BUFFER_STATS_EN
        , .aw_level(aw_level1), .aw_peak(aw_peak1), .w_level(w_level1), .w_peak(w_peak1)
        , .b_level(b_level1), .b_peak(b_peak1), .ar_level(ar_level1), .ar_peak(ar_peak1)
        , .r_level(r_level1), .r_peak(r_peak1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int beats_out = 0;
    logic [79:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];

    typedef struct {
        logic       mv;
        logic [3:0] id;
        logic [1:0] resp;
        logic       sr;
        logic       exp_sv;
        logic [3:0] exp_id;
        logic [1:0] exp_resp;
        logic       exp_mr;
    } bvec_t;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic zeroHandshakes();
        s0.aw_valid = 0; s0.w_valid = 0; s0.ar_valid = 0; s0.b_ready = 0; s0.r_ready = 0;
        m0.aw_ready = 0; m0.w_ready = 0; m0.ar_ready = 0; m0.b_valid = 0; m0.r_valid = 0;
        s1.aw_valid = 0; s1.w_valid = 0; s1.ar_valid = 0; s1.b_ready = 0; s1.r_ready = 0;
        m1.aw_ready = 0; m1.w_ready = 0; m1.ar_ready = 0; m1.b_valid = 0; m1.r_valid = 0;
    endtask

    // Scoreboard on dut0: capture every accepted upstream beat, compare every downstream beat.
    always @(negedge clk) begin
        logic [79:0] exp;
        if (rst) begin
            aw_q.delete(); w_q.delete(); b_q.delete(); ar_q.delete(); r_q.delete();
        end else begin
            if (s0.aw_valid && s0.aw_ready)
                aw_q.push_back(80'({s0.aw_id, s0.aw_addr, s0.aw_len, s0.aw_size, s0.aw_burst,
                    s0.aw_lock, s0.aw_cache, s0.aw_prot, s0.aw_qos, s0.aw_region, s0.aw_user}));
            if (s0.w_valid && s0.w_ready)
                w_q.push_back(80'({s0.w_data, s0.w_strb, s0.w_last, s0.w_user}));
            if (m0.b_valid && m0.b_ready)
                b_q.push_back(80'({m0.b_id, m0.b_resp, m0.b_user}));
            if (s0.ar_valid && s0.ar_ready)
                ar_q.push_back(80'({s0.ar_id, s0.ar_addr, s0.ar_len, s0.ar_size, s0.ar_burst,
                    s0.ar_lock, s0.ar_cache, s0.ar_prot, s0.ar_qos, s0.ar_region, s0.ar_user}));
            if (m0.r_valid && m0.r_ready)
                r_q.push_back(80'({m0.r_id, m0.r_data, m0.r_resp, m0.r_last, m0.r_user}));

            if (m0.aw_valid && m0.aw_ready) begin
                exp = (aw_q.size() > 0) ? aw_q.pop_front() : 'x;
                checkOutput("aw_beat", 80'({m0.aw_id, m0.aw_addr, m0.aw_len, m0.aw_size, m0.aw_burst,
                    m0.aw_lock, m0.aw_cache, m0.aw_prot, m0.aw_qos, m0.aw_region, m0.aw_user}), exp);
                beats_out++;
            end
            if (m0.w_valid && m0.w_ready) begin
                exp = (w_q.size() > 0) ? w_q.pop_front() : 'x;
                checkOutput("w_beat", 80'({m0.w_data, m0.w_strb, m0.w_last, m0.w_user}), exp);
                beats_out++;
            end
            if (s0.b_valid && s0.b_ready) begin
                exp = (b_q.size() > 0) ? b_q.pop_front() : 'x;
                checkOutput("b_beat", 80'({s0.b_id, s0.b_resp, s0.b_user}), exp);
                beats_out++;
            end
            if (m0.ar_valid && m0.ar_ready) begin
                exp = (ar_q.size() > 0) ? ar_q.pop_front() : 'x;
                checkOutput("ar_beat", 80'({m0.ar_id, m0.ar_addr, m0.ar_len, m0.ar_size, m0.ar_burst,
                    m0.ar_lock, m0.ar_cache, m0.ar_prot, m0.ar_qos, m0.ar_region, m0.ar_user}), exp);
                beats_out++;
            end
            if (s0.r_valid && s0.r_ready) begin
                exp = (r_q.size() > 0) ? r_q.pop_front() : 'x;
                checkOutput("r_beat", 80'({s0.r_id, s0.r_data, s0.r_resp, s0.r_last, s0.r_user}), exp);
                beats_out++;
            end
        end
    end

    task automatic applyStimulus(input bvec_t v, input int idx);
        m0.b_valid = v.mv; m0.b_id = v.id; m0.b_resp = v.resp; m0.b_user = 1'b0;
        s0.b_ready = v.sr;
        @(negedge clk);
        checkOutput($sformatf("b_pass_valid[%0d]", idx), 80'(s0.b_valid), 80'(v.exp_sv));
        checkOutput($sformatf("b_pass_id[%0d]", idx), 80'(s0.b_id), 80'(v.exp_id));
        checkOutput($sformatf("b_pass_resp[%0d]", idx), 80'(s0.b_resp), 80'(v.exp_resp));
        checkOutput($sformatf("b_pass_ready[%0d]", idx), 80'(m0.b_ready), 80'(v.exp_mr));
        cycle();
    endtask

    task automatic runBursts();
        int sent0 = 0, sent1 = 0, got0 = 0, got1 = 0, cyc = 0, done0 = 0, done1 = 0;
        m0.r_id = 4'h2; m0.r_resp = 2'b00; m0.r_user = 1'b0;
        m1.r_id = 4'h2; m1.r_resp = 2'b00; m1.r_user = 1'b0;
        s0.r_ready = 1; s1.r_ready = 1;
        while ((got0 < 256 || got1 < 256) && cyc < 1200) begin
            cyc++;
            m0.r_valid = (sent0 < 256); m0.r_data = 32'(sent0); m0.r_last = (sent0 == 255);
            m1.r_valid = (sent1 < 256); m1.r_data = 32'(sent1); m1.r_last = (sent1 == 255);
            @(negedge clk);
            if (m0.r_valid && m0.r_ready) sent0++;
            if (m1.r_valid && m1.r_ready) sent1++;
            if (s0.r_valid && s0.r_ready) begin
                got0++;
                if (got0 == 256) done0 = cyc;
            end
            if (s1.r_valid && s1.r_ready) begin
                checkOutput("r1_data", 80'(s1.r_data), 80'(got1));
                checkOutput("r1_last", 80'(s1.r_last), 80'(got1 == 255));
                got1++;
                if (got1 == 256) done1 = cyc;
            end
            cycle();
        end
        m0.r_valid = 0; m1.r_valid = 0;
        checkOutput("r_depth2_cycles", 80'(done0), 80'(257));
        checkOutput("r_depth1_cycles_in_range", 80'(done1 >= 511 && done1 <= 513), 80'(1));
    endtask

    task automatic runRandom(input int target);
        int cyc = 0;
        bit aw_hs = 1, w_hs = 1, ar_hs = 1, b_hs = 1, r_hs = 1;
        beats_out = 0;
        while (beats_out < target && cyc < 40000) begin
            if (!s0.aw_valid || aw_hs) begin
                s0.aw_valid = 1'($urandom_range(0, 1));
                {s0.aw_id, s0.aw_addr, s0.aw_len, s0.aw_size, s0.aw_burst, s0.aw_lock,
                 s0.aw_cache, s0.aw_prot, s0.aw_qos, s0.aw_region, s0.aw_user} = AW_PW'(rnd80());
            end
            if (!s0.w_valid || w_hs) begin
                s0.w_valid = 1'($urandom_range(0, 1));
                {s0.w_data, s0.w_strb, s0.w_last, s0.w_user} = W_PW'(rnd80());
            end
            if (!s0.ar_valid || ar_hs) begin
                s0.ar_valid = 1'($urandom_range(0, 1));
                {s0.ar_id, s0.ar_addr, s0.ar_len, s0.ar_size, s0.ar_burst, s0.ar_lock,
                 s0.ar_cache, s0.ar_prot, s0.ar_qos, s0.ar_region, s0.ar_user} = AW_PW'(rnd80());
            end
            if (!m0.b_valid || b_hs) begin
                m0.b_valid = 1'($urandom_range(0, 1));
                {m0.b_id, m0.b_resp, m0.b_user} = B_PW'(rnd80());
            end
            if (!m0.r_valid || r_hs) begin
                m0.r_valid = 1'($urandom_range(0, 1));
                {m0.r_id, m0.r_data, m0.r_resp, m0.r_last, m0.r_user} = R_PW'(rnd80());
            end
            m0.aw_ready = 1'($urandom_range(0, 1));
            m0.w_ready  = 1'($urandom_range(0, 1));
            m0.ar_ready = 1'($urandom_range(0, 1));
            s0.b_ready  = 1'($urandom_range(0, 1));
            s0.r_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            aw_hs = s0.aw_valid && s0.aw_ready;
            w_hs  = s0.w_valid && s0.w_ready;
            ar_hs = s0.ar_valid && s0.ar_ready;
            b_hs  = m0.b_valid && m0.b_ready;
            r_hs  = m0.r_valid && m0.r_ready;
            cycle();
            cyc++;
        end
        checkOutput("random_reached_target", 80'(beats_out >= target), 80'(1));
        s0.aw_valid = 0; s0.w_valid = 0; s0.ar_valid = 0; m0.b_valid = 0; m0.r_valid = 0;
        m0.aw_ready = 1; m0.w_ready = 1; m0.ar_ready = 1; s0.b_ready = 1; s0.r_ready = 1;
        repeat (12) cycle();
        checkOutput("random_nothing_lost",
                    80'(aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size()), 80'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bvec_t bvecs[4];
        int got;
        bit acc;

        bvecs[0] = '{mv: 1, id: 4'h5, resp: 2'b10, sr: 1, exp_sv: 1, exp_id: 4'h5, exp_resp: 2'b10, exp_mr: 1};
        bvecs[1] = '{mv: 1, id: 4'h5, resp: 2'b10, sr: 0, exp_sv: 1, exp_id: 4'h5, exp_resp: 2'b10, exp_mr: 0};
        bvecs[2] = '{mv: 0, id: 4'h3, resp: 2'b00, sr: 1, exp_sv: 0, exp_id: 4'h3, exp_resp: 2'b00, exp_mr: 1};
        bvecs[3] = '{mv: 1, id: 4'hA, resp: 2'b01, sr: 0, exp_sv: 1, exp_id: 4'hA, exp_resp: 2'b01, exp_mr: 0};

        zeroHandshakes();
        rst = 1;

        // Reset held three cycles: every buffered valid and ready is low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_handshakes_low",
                        80'({s0.aw_ready, s0.w_ready, s0.ar_ready, m0.r_ready,
                             m0.aw_valid, m0.w_valid, m0.ar_valid, s0.r_valid,
                             s1.aw_ready, s1.r_valid, m1.aw_valid, m1.r_ready}), 80'(0));
        end
        cycle();
        rst = 0;
        @(negedge clk);
        checkOutput("post_reset_aw_ready", 80'(s0.aw_ready), 80'(1));
        checkOutput("post_reset_aw_valid", 80'(m0.aw_valid), 80'(0));
        checkOutput("post_reset_readies", 80'({s0.w_ready, s0.ar_ready, m0.r_ready}), 80'(3'b111));

        // Single AW beat with one cycle of latency.
        cycle();
        m0.aw_ready = 0;
        s0.aw_valid = 1; s0.aw_id = 4'h3; s0.aw_addr = 32'h1000; s0.aw_len = 8'd3;
        s0.aw_size = 3'd2; s0.aw_burst = 2'b01; s0.aw_lock = 0; s0.aw_cache = 4'h0;
        s0.aw_prot = 3'd0; s0.aw_qos = 4'h0; s0.aw_region = 4'h0; s0.aw_user = 1'b0;
        @(negedge clk);
        checkOutput("aw_not_yet_valid", 80'(m0.aw_valid), 80'(0));
        cycle();
        s0.aw_valid = 0;
        @(negedge clk);
        checkOutput("aw_valid_after_1", 80'(m0.aw_valid), 80'(1));
        checkOutput("aw_addr", 80'(m0.aw_addr), 80'(32'h1000));
        checkOutput("aw_len", 80'(m0.aw_len), 80'(3));
        checkOutput("aw_id", 80'(m0.aw_id), 80'(4'h3));
        cycle();
        m0.aw_ready = 1;
        cycle();
        @(negedge clk);
        checkOutput("aw_drained", 80'(m0.aw_valid), 80'(0));
        cycle();

        // Fill the 4-deep W FIFO, hold a 5th beat, then drain in order.
        m0.w_ready = 0;
        s0.w_strb = 4'hF; s0.w_user = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s0.w_valid = 1; s0.w_data = 32'hA0 + 32'(i); s0.w_last = 0;
            @(negedge clk);
            checkOutput("w_ready_while_filling", 80'(s0.w_ready), 80'(1));
            cycle();
        end
        s0.w_data = 32'hA4; s0.w_last = 1;
        @(negedge clk);
        checkOutput("w_ready_when_full", 80'(s0.w_ready), 80'(0));
        cycle();
        @(negedge clk);
        checkOutput("w_fifth_still_held", 80'(s0.w_ready), 80'(0));
        checkOutput("w_head_is_a0", 80'(m0.w_data), 80'(32'hA0));
        cycle();
        m0.w_ready = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            if (m0.w_valid) got++;
            acc = s0.w_valid && s0.w_ready;
            cycle();
            if (acc) s0.w_valid = 0;
        end
        checkOutput("w_drain_count", 80'(got), 80'(5));

        // Pass-through B channel: combinational in both directions.
        for (int i = 0; i < 4; i++) applyStimulus(bvecs[i], i);
        m0.b_valid = 0; s0.b_ready = 0;

        runBursts();
        runRandom(10000);

        // Reset in the middle of traffic with beats held in several FIFOs.
        m0.aw_ready = 0; m0.w_ready = 0; m0.ar_ready = 0; s0.r_ready = 0;
        s0.aw_valid = 1; s0.w_valid = 1; s0.ar_valid = 1; m0.r_valid = 1;
        repeat (2) cycle();
        @(negedge clk);
        checkOutput("pre_reset_valids", 80'({m0.aw_valid, m0.w_valid, m0.ar_valid, s0.r_valid}), 80'(4'hF));
        cycle();
        rst = 1;
        zeroHandshakes();
        @(negedge clk);
        checkOutput("valids_drop_with_reset", 80'({m0.aw_valid, m0.w_valid, m0.ar_valid, s0.r_valid}), 80'(0));
        cycle();
        rst = 0;
        m0.r_ready = 0;
        @(negedge clk);
        checkOutput("post_mid_reset_valids", 80'({m0.aw_valid, m0.w_valid, m0.ar_valid, s0.r_valid}), 80'(0));
        checkOutput("post_mid_reset_readies", 80'({s0.aw_ready, s0.w_ready, s0.ar_ready, m0.r_ready}), 80'(4'hF));
        cycle();

`ifdef AXI_BUFFER_STATS_EN
        // AR occupancy climbs to 3, drains to 0, and the peak survives until reset.
        m0.ar_ready = 0;
        @(negedge clk);
        checkOutput("ar_level_start", 80'(ar_level0), 80'(0));
        checkOutput("ar_peak_start", 80'(ar_peak0), 80'(0));
        cycle();
        for (int i = 1; i <= 3; i++) begin
            s0.ar_valid = 1;
            {s0.ar_id, s0.ar_addr, s0.ar_len, s0.ar_size, s0.ar_burst, s0.ar_lock,
             s0.ar_cache, s0.ar_prot, s0.ar_qos, s0.ar_region, s0.ar_user} = AW_PW'(rnd80());
            cycle();
            s0.ar_valid = 0;
            @(negedge clk);
            checkOutput("ar_level_fill", 80'(ar_level0), 80'(i));
        end
        checkOutput("ar_peak_full", 80'(ar_peak0), 80'(3));
        cycle();
        m0.ar_ready = 1;
        for (int i = 2; i >= 0; i--) begin
            cycle();
            @(negedge clk);
            checkOutput("ar_level_drain", 80'(ar_level0), 80'(i));
        end
        checkOutput("ar_peak_after_drain", 80'(ar_peak0), 80'(3));
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        @(negedge clk);
        checkOutput("ar_peak_cleared", 80'(ar_peak0), 80'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
